// File: rtl/axi_arbiter.sv
// N-port request arbiter with round-robin or fixed priority and optional grant blocking.
// Grant, valid flag and encoded index are all registered; nothing reaches the outputs combinationally.
module axi_arbiter #(
  parameter int PORTS                 = 6,
  parameter int ARB_TYPE_ROUND_ROBIN  = 1,
  parameter int ARB_BLOCK             = 1,
  parameter int ARB_BLOCK_ACK         = 1,
  parameter int ARB_LSB_HIGH_PRIORITY = 1
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic [PORTS-1:0]                  request,
  input  logic [PORTS-1:0]                  acknowledge,
  output logic [PORTS-1:0]                  grant,
  output logic                              grant_valid,
  output logic [((PORTS > 1) ? $clog2(PORTS) : 1)-1:0] grant_encoded
);

  localparam int IW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam logic [PORTS-1:0] ONES = '1;
  localparam logic [PORTS-1:0] ONE  = PORTS'(1);

  logic [PORTS-1:0] mask;
  logic [IW-1:0]    req_idx;
  logic [IW-1:0]    masked_idx;
  logic [IW-1:0]    win_idx;
  logic             masked_valid;
  logic             hold_req;
  logic             hold_ack;

  // Index of the highest-priority set bit; the last assignment in the scan wins.
  function automatic logic [IW-1:0] pe_index(input logic [PORTS-1:0] x);
    logic [IW-1:0] idx;
    idx = '0;
    if (ARB_LSB_HIGH_PRIORITY != 0) begin
      for (int i = PORTS - 1; i >= 0; i--)
        if (x[i]) idx = IW'(i);
    end else begin
      for (int i = 0; i < PORTS; i++)
        if (x[i]) idx = IW'(i);
    end
    return idx;
  endfunction

  always_comb begin
    req_idx      = pe_index(request);
    masked_idx   = pe_index(request & mask);
    masked_valid = |(request & mask);
    win_idx      = ((ARB_TYPE_ROUND_ROBIN != 0) && masked_valid) ? masked_idx : req_idx;
    hold_req     = (ARB_BLOCK != 0) && (ARB_BLOCK_ACK == 0) && (|(grant & request));
    hold_ack     = (ARB_BLOCK != 0) && (ARB_BLOCK_ACK != 0) && grant_valid &&
                   !(|(grant & acknowledge));
  end

  // The mask keeps only ports of lower priority than the last winner, so the
  // next masked pick continues the rotation and an empty mask wraps around.
  always_ff @(posedge clk) begin
    if (resetn) begin
      grant         <= '0;
      grant_valid   <= 1'b0;
      grant_encoded <= '0;
      mask          <= '0;
    end else if (hold_req || hold_ack) begin
      grant         <= grant;
      grant_valid   <= grant_valid;
      grant_encoded <= grant_encoded;
      mask          <= mask;
    end else if (|request) begin
      grant         <= ONE << win_idx;
      grant_valid   <= 1'b1;
      grant_encoded <= win_idx;
      if (ARB_TYPE_ROUND_ROBIN != 0) begin
        if (ARB_LSB_HIGH_PRIORITY != 0)
          mask <= ONES << (int'(win_idx) + 1);
        else
          mask <= ONES >> (PORTS - int'(win_idx));
      end
    end else begin
      grant         <= '0;
      grant_valid   <= 1'b0;
      grant_encoded <= '0;
    end
  end

endmodule

// File: tb/tb_axi_arbiter.sv
// Self-checking bench for axi_arbiter: five parameter variants share one stimulus stream
// and are compared every cycle against a pointer-based reference model.
module tb_axi_arbiter;

  localparam int P  = 6;
  localparam int NI = 5;

  // Variants: 0 default, 1 MSB priority, 2 release on request drop, 3 fixed priority, 4 no blocking
  int cfg_rr  [NI] = '{1, 1, 1, 0, 1};
  int cfg_blk [NI] = '{1, 1, 1, 1, 0};
  int cfg_ack [NI] = '{1, 1, 0, 1, 1};
  int cfg_lsb [NI] = '{1, 0, 1, 1, 1};

  logic         clk;
  logic         resetn;
  logic [P-1:0] request;
  logic [P-1:0] acknowledge;
  logic [P-1:0] g  [NI];
  logic         gv [NI];
  logic [2:0]   ge [NI];

  int n_compared;
  int n_mismatched;
  int m_gnt  [NI];
  int m_last [NI];

  axi_arbiter #(.PORTS(P), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(1),
                .ARB_LSB_HIGH_PRIORITY(1)) dut0 (
    .clk(clk), .resetn(resetn), .request(request), .acknowledge(acknowledge),
    .grant(g[0]), .grant_valid(gv[0]), .grant_encoded(ge[0]));
  axi_arbiter #(.PORTS(P), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(1),
                .ARB_LSB_HIGH_PRIORITY(0)) dut1 (
    .clk(clk), .resetn(resetn), .request(request), .acknowledge(acknowledge),
    .grant(g[1]), .grant_valid(gv[1]), .grant_encoded(ge[1]));
  axi_arbiter #(.PORTS(P), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(0),
                .ARB_LSB_HIGH_PRIORITY(1)) dut2 (
    .clk(clk), .resetn(resetn), .request(request), .acknowledge(acknowledge),
    .grant(g[2]), .grant_valid(gv[2]), .grant_encoded(ge[2]));
  axi_arbiter #(.PORTS(P), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(1), .ARB_BLOCK_ACK(1),
                .ARB_LSB_HIGH_PRIORITY(1)) dut3 (
    .clk(clk), .resetn(resetn), .request(request), .acknowledge(acknowledge),
    .grant(g[3]), .grant_valid(gv[3]), .grant_encoded(ge[3]));
  axi_arbiter #(.PORTS(P), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(0), .ARB_BLOCK_ACK(1),
                .ARB_LSB_HIGH_PRIORITY(1)) dut4 (
    .clk(clk), .resetn(resetn), .request(request), .acknowledge(acknowledge),
    .grant(g[4]), .grant_valid(gv[4]), .grant_encoded(ge[4]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Round robin remembers the last winner and looks for the next requester past it
  // in priority order, wrapping to the top-priority requester when none is left.
  function automatic int pick(int k, logic [P-1:0] req);
    if (cfg_lsb[k] != 0) begin
      if (cfg_rr[k] != 0)
        for (int i = m_last[k] + 1; i < P; i++) if (req[i]) return i;
      for (int i = 0; i < P; i++) if (req[i]) return i;
    end else begin
      if (cfg_rr[k] != 0)
        for (int i = m_last[k] - 1; i >= 0; i--) if (req[i]) return i;
      for (int i = P - 1; i >= 0; i--) if (req[i]) return i;
    end
    return -1;
  endfunction

  task automatic modelStep(input int k);
    if (resetn) begin
      m_gnt[k]  = -1;
      m_last[k] = (cfg_lsb[k] != 0) ? -1 : P;
    end else if (cfg_blk[k] != 0 && cfg_ack[k] == 0 && m_gnt[k] >= 0 && request[m_gnt[k]]) begin
      m_gnt[k] = m_gnt[k];
    end else if (cfg_blk[k] != 0 && cfg_ack[k] != 0 && m_gnt[k] >= 0 && !acknowledge[m_gnt[k]]) begin
      m_gnt[k] = m_gnt[k];
    end else if (request != '0) begin
      m_gnt[k] = pick(k, request);
      if (cfg_rr[k] != 0) m_last[k] = m_gnt[k];
    end else begin
      m_gnt[k] = -1;
    end
  endtask

  function automatic logic [P-1:0] onehot(int idx);
    logic [P-1:0] v;
    v = '0;
    if (idx >= 0) v[idx] = 1'b1;
    return v;
  endfunction

  // Drive one cycle of inputs, advance the model, then compare every variant after the edge.
  task automatic applyStimulus(input logic [P-1:0] req, input logic [P-1:0] ack, input logic rst);
    request     = req;
    acknowledge = ack;
    resetn      = rst;
    for (int k = 0; k < NI; k++) modelStep(k);
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      checkOutput($sformatf("grant%0d", k), 32'(g[k]), 32'(onehot(m_gnt[k])));
      checkOutput($sformatf("valid%0d", k), 32'(gv[k]), 32'(m_gnt[k] >= 0));
      checkOutput($sformatf("enc%0d", k), 32'(ge[k]), (m_gnt[k] >= 0) ? m_gnt[k] : 0);
    end
  endtask

  initial begin
    logic [P-1:0] r;
    logic [P-1:0] a;
    n_compared   = 0;
    n_mismatched = 0;
    for (int k = 0; k < NI; k++) begin
      m_gnt[k]  = -1;
      m_last[k] = -1;
    end
    request     = '0;
    acknowledge = '0;
    resetn      = 1'b1;

    applyStimulus(6'b111111, 6'b000000, 1'b1);
    applyStimulus(6'b111111, 6'b000000, 1'b1);
    checkOutput("rst_grant", 32'(g[0]), 32'h0);
    checkOutput("rst_valid", 32'(gv[0]), 32'h0);
    checkOutput("rst_enc", 32'(ge[0]), 32'h0);

    applyStimulus(6'b000101, 6'b000000, 1'b0);
    checkOutput("first_grant", 32'(g[0]), 32'b000001);
    checkOutput("first_valid", 32'(gv[0]), 32'h1);
    checkOutput("msb_grant", 32'(g[1]), 32'b000100);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(6'b100100, 6'b000000, 1'b0);
      checkOutput("block_hold", 32'(g[0]), 32'b000001);
    end

    applyStimulus(6'b000101, 6'b000001, 1'b0);
    checkOutput("rr_next", 32'(g[0]), 32'b000100);
    checkOutput("rr_next_enc", 32'(ge[0]), 32'd2);
    applyStimulus(6'b000101, 6'b000000, 1'b0);
    applyStimulus(6'b000101, 6'b000100, 1'b0);
    checkOutput("rr_wrap", 32'(g[0]), 32'b000001);

    for (int i = 0; i < P; i++) begin
      a = '0;
      a[i] = 1'b1;
      applyStimulus(6'b111111, a, 1'b0);
      checkOutput("fair_enc", 32'(ge[0]), (i + 1) % P);
    end

    applyStimulus(6'b000000, 6'b000001, 1'b0);
    checkOutput("idle_grant", 32'(g[0]), 32'h0);
    checkOutput("idle_valid", 32'(gv[0]), 32'h0);

    applyStimulus(6'b000100, 6'b000000, 1'b0);
    checkOutput("pre_rst_grant", 32'(g[0]), 32'b000100);
    applyStimulus(6'b000100, 6'b000000, 1'b1);
    checkOutput("mid_rst_grant", 32'(g[0]), 32'h0);
    checkOutput("mid_rst_enc", 32'(ge[0]), 32'h0);
    applyStimulus(6'b000100, 6'b000000, 1'b0);
    checkOutput("post_rst_grant", 32'(g[0]), 32'b000100);
    applyStimulus(6'b000100, 6'b000100, 1'b0);
    checkOutput("regrant_same", 32'(g[0]), 32'b000100);
    checkOutput("reqrel_hold", 32'(g[2]), 32'b000100);
    applyStimulus(6'b000001, 6'b000000, 1'b0);
    checkOutput("reqrel_drop", 32'(g[2]), 32'b000001);
    checkOutput("ack_still_hold", 32'(g[0]), 32'b000100);

    for (int i = 0; i < 400; i++) begin
      r = P'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) r = '0;
      if ($urandom_range(0, 1) == 0) a = onehot(m_gnt[$urandom_range(0, NI - 1)]);
      else a = P'($urandom_range(0, 63)) & P'($urandom_range(0, 63));
      applyStimulus(r, a, $urandom_range(0, 49) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/axi_arbiter.md
Name: axi_arbiter

Overview:
- Parameterised N-port request arbiter used by the AXI interconnect to select one master (or slave response) per transaction.
- Supports round-robin or fixed priority, selectable LSB/MSB priority, and optional blocking that holds a grant until acknowledge or until the request drops.
- Outputs are registered: a one-hot grant, a valid flag and a binary-encoded index.

Parameters:
- PORTS, 6: number of requesters. Must be >= 2.
- ARB_TYPE_ROUND_ROBIN, 1: 1 = round robin; 0 = fixed priority.
- ARB_BLOCK, 1: 1 = hold the current grant while blocked; 0 = re-arbitrate every cycle.
- ARB_BLOCK_ACK, 1: applies only when ARB_BLOCK=1. 1 = release on acknowledge; 0 = release when the granted request deasserts.
- ARB_LSB_HIGH_PRIORITY, 1: 1 = lowest index wins ties; 0 = highest index wins.

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- resetn, input, 1: synchronous, active-high reset (resetn=1 resets).
- request, input, PORTS: per-port request, level sensitive.
- acknowledge, input, PORTS: per-port transaction-done strobe.
- grant, output, PORTS: one-hot grant, registered.
- grant_valid, output, 1: high when grant is nonzero, registered.
- grant_encoded, output, $clog2(PORTS): index of the granted port, registered.

Behaviour:
- Reset: on the rising edge with resetn=1, grant=0, grant_valid=0, grant_encoded=0 and the internal round-robin mask=0.
- Reset has priority over every other event, including mid-grant.
- All outputs update one cycle after the inputs are sampled. There is no combinational path from the inputs to the outputs.
- Priority encoder PE(x): returns valid = |x, plus the index and one-hot of the highest-priority set bit.
  - Highest priority is the lowest index if ARB_LSB_HIGH_PRIORITY=1, otherwise the highest index.
- Each cycle, the first matching case below applies.
  1. Hold (request-released). Condition: ARB_BLOCK=1, ARB_BLOCK_ACK=0, and (grant & request) != 0. Action: all outputs and the mask hold.
  2. Hold (ack-released). Condition: ARB_BLOCK=1, ARB_BLOCK_ACK=1, grant_valid=1, and (grant & acknowledge) == 0. Action: all outputs and the mask hold.
  3. New grant. Condition: request != 0. Action:
     - Fixed priority: grant = PE(request).
     - Round robin, PE(request & mask) valid: grant the masked winner.
     - Round robin, otherwise: grant PE(request), which wraps around.
     - Set grant_valid=1 and grant_encoded to the winner's index.
     - Round robin only, update the mask to exclude the winner and every higher-priority port:
       - LSB priority: mask = all-ones << (idx+1).
       - MSB priority: mask = all-ones >> (PORTS-idx).
  4. Idle. Condition: none of the above. Action: grant=0, grant_valid=0, grant_encoded=0; the mask holds.
- Acknowledge on a port that is not granted is ignored.
- With ARB_BLOCK_ACK=1, the cycle that sees the acknowledge performs a new arbitration. The same port may be re-granted back-to-back if it is the only requester.
- With ARB_BLOCK=0, arbitration happens every cycle.
  - Round robin then rotates among active requesters each cycle.
- grant is always zero or one-hot.
- grant_valid == |grant at all times.

Test Plan:
- Reset: hold resetn=1 with request=6'b111111 -> grant=0, grant_valid=0, grant_encoded=0. Release with request=6'b000101 -> next cycle grant=6'b000001, grant_encoded=0, grant_valid=1.
- Blocking on acknowledge: with port 0 granted, change request to 6'b100100 and keep acknowledge=0 for 5 cycles -> grant stays 6'b000001.
- Round robin: request=6'b000101, pulse acknowledge=6'b000001 -> next grant=6'b000100 (encoded 2). Pulse acknowledge=6'b000100 -> grant wraps to 6'b000001.
- Fairness: all six ports request; acknowledge the granted port every cycle -> encoded sequence 0,1,2,3,4,5,0.
- Idle: request=0 and acknowledge the granted port -> next cycle grant=0, grant_valid=0, grant_encoded=0.
- Reset mid-operation and variants:
  - Assert resetn while port 2 is granted -> outputs clear the next cycle.
  - After release with request=6'b000100, port 2 is re-granted (mask was cleared).
  - Repeat the suite with ARB_LSB_HIGH_PRIORITY=0: request=6'b000101 -> grant=6'b000100.
  - Repeat with ARB_BLOCK_ACK=0: the grant releases only when request[2] drops.
